// File: rtl/job_control.sv
// Job control front end: decodes PSL job commands, sequences the job state
// machine and drives the AFU job-status outputs plus datapath strobes.
module job_control #(
  parameter int unsigned RESET_CYCLES = 4,
  parameter bit          PARITY_CHECK = 1'b1
) (
  input  logic        ha_pclock,
  input  logic        reset,
  input  logic        ha_jval,
  input  logic [0:7]  ha_jcom,
  input  logic        ha_jcompar,
  input  logic [0:63] ha_jea,
  input  logic        ha_jeapar,
  input  logic        dp_done,
  input  logic [0:63] dp_error,
  output logic        ah_jrunning,
  output logic        ah_jdone,
  output logic        ah_jcack,
  output logic [0:63] ah_jerror,
  output logic        ah_jyield,
  output logic        ah_tbreq,
  output logic [0:63] job_wed,
  output logic        job_start,
  output logic        job_reset
);

  localparam logic [7:0] CmdReset    = 8'h80;
  localparam logic [7:0] CmdStart    = 8'h90;
  localparam logic [7:0] CmdTimebase = 8'h42;
  localparam logic [7:0] CmdLlcmd    = 8'h45;

  localparam logic [63:0] ErrComPar  = 64'd1;
  localparam logic [63:0] ErrEaPar   = 64'd2;
  localparam logic [63:0] ErrBadStart = 64'd3;
  localparam logic [63:0] ErrInvalid = 64'd4;

  typedef enum logic [1:0] {StIdle, StResetting, StRunning} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        jdone_d, jcack_d, tbreq_d, start_d;
  logic [0:63] jerror_d, wed_d;

  logic        com_ok, ea_ok;
  logic        is_reset, is_start, is_tb, is_ll;
  logic        passive;

  // Command decode and parity qualification.
  always_comb begin
    com_ok   = (PARITY_CHECK == 1'b0) || (^{ha_jcom, ha_jcompar});
    ea_ok    = (PARITY_CHECK == 1'b0) || (^{ha_jea, ha_jeapar});
    is_reset = (ha_jcom == CmdReset);
    is_start = (ha_jcom == CmdStart);
    is_tb    = (ha_jcom == CmdTimebase);
    is_ll    = (ha_jcom == CmdLlcmd);
    // TIMEBASE/LLCMD do not disturb the state machine, so dp_done and the
    // reset countdown still proceed alongside them.
    passive  = !ha_jval || (com_ok && (is_tb || is_ll));
  end

  // State register plus registered outputs.
  always_ff @(posedge ha_pclock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= 8'd0;
      ah_jrunning <= 1'b0;
      ah_jdone    <= 1'b0;
      ah_jcack    <= 1'b0;
      ah_jerror   <= '0;
      ah_tbreq    <= 1'b0;
      job_wed     <= '0;
      job_start   <= 1'b0;
      job_reset   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ah_jrunning <= (state_d == StRunning);
      ah_jdone    <= jdone_d;
      ah_jcack    <= jcack_d;
      ah_jerror   <= jerror_d;
      ah_tbreq    <= tbreq_d;
      job_wed     <= wed_d;
      job_start   <= start_d;
      job_reset   <= (state_d == StResetting);
    end
  end

  // Next-state logic: commands first, then countdown / datapath completion.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (ha_jval) begin
      if (!com_ok) begin
        state_d = StIdle;
      end else if (is_reset) begin
        state_d = StResetting;
        cnt_d   = RESET_CYCLES[7:0];
      end else if (is_start) begin
        state_d = (ea_ok && state_q == StIdle) ? StRunning : StIdle;
      end else if (!(is_tb || is_ll)) begin
        state_d = StIdle;
      end
    end
    if (passive) begin
      unique case (state_q)
        StResetting: begin
          if (cnt_q == 8'd0) state_d = StIdle;
          else               cnt_d   = cnt_q - 8'd1;
        end
        StRunning: if (dp_done) state_d = StIdle;
        default: ;
      endcase
    end
  end

  // Output logic: next values of the pulse outputs, error code and WED.
  always_comb begin
    jdone_d  = 1'b0;
    jerror_d = '0;
    jcack_d  = 1'b0;
    tbreq_d  = 1'b0;
    start_d  = 1'b0;
    wed_d    = job_wed;
    if (ha_jval) begin
      if (!com_ok) begin
        jdone_d  = 1'b1;
        jerror_d = ErrComPar;
      end else if (is_reset) begin
        jdone_d = 1'b0;
      end else if (is_start) begin
        if (!ea_ok) begin
          jdone_d  = 1'b1;
          jerror_d = ErrEaPar;
        end else if (state_q == StIdle) begin
          start_d = 1'b1;
          wed_d   = ha_jea;
        end else begin
          jdone_d  = 1'b1;
          jerror_d = ErrBadStart;
        end
      end else if (is_tb) begin
        tbreq_d = (state_q != StResetting);
      end else if (is_ll) begin
        jcack_d = (state_q == StRunning);
      end else begin
        jdone_d  = 1'b1;
        jerror_d = ErrInvalid;
      end
    end
    if (passive) begin
      if (state_q == StResetting && cnt_q == 8'd0) begin
        jdone_d  = 1'b1;
        jerror_d = '0;
      end else if (state_q == StRunning && dp_done) begin
        jdone_d  = 1'b1;
        jerror_d = dp_error;
      end
    end
  end

  assign ah_jyield = 1'b0;

endmodule
